bcd_lap_stopwatch: RTL and testbench
====================================

Name: bcd_lap_stopwatch

Overview:
Parametrised next-generation stopwatch. It counts time units in a BCD digit chain, so no divide/modulo is needed for display, and it runs either up or down.
- Up mode: stopwatch.
- Down mode: countdown timer with an expiry flag.
- Lap freeze: the display holds a snapshot while counting continues.
- Sits between the edge-detected button inputs and the per-digit seven-segment decoders.
- Control inputs are single-cycle pulses from the existing rising-edge detector.

Parameters:
- NUM_DIGITS, 4, number of BCD digits in the counter and display.
- TICKS_PER_UNIT, 50000000, clk cycles per counted unit. Must be >= 2.
- PRESCALE_W, 26, prescaler width. Must satisfy 2**PRESCALE_W >= TICKS_PER_UNIT.

Ports:
- clk  input  1  system clock.
- sync_reset  input  1  synchronous, active-high reset.
- start  input  1  pulse: load the counter and begin running.
- continue_pause  input  1  pulse: toggle between RUNNING and PAUSED.
- lap  input  1  pulse: toggle display freeze.
- mode_down  input  1  0 = count up, 1 = count down. Sampled only on start.
- load_bcd  input  NUM_DIGITS*4  countdown start value, BCD, digit 0 in LSBs.
- digits_bcd  output  NUM_DIGITS*4  displayed value: lap snapshot if frozen, else live count.
- running  output  1  high in RUNNING.
- lap_active  output  1  display frozen.
- expired  output  1  down mode reached zero. Sticky until start or reset.
- overflow  output  1  up mode wrapped from all-9s to 0. Sticky until start or reset.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (sync_reset). All state changes on the rising clk edge; outputs are registered.
- Reset values: state IDLE; count, lap snapshot and prescaler 0; digits_bcd, running, lap_active, expired and overflow all 0; registered mode 0.
- Event priority in one cycle: sync_reset > start > continue_pause > lap. Only the highest-priority pulse acts; lower ones are ignored, not queued.
- States:
  - IDLE → RUNNING on start.
  - RUNNING ↔ PAUSED on continue_pause.
  - RUNNING → EXPIRED when a down-mode decrement reaches 0.
  - continue_pause is ignored in IDLE and EXPIRED.
- start (in any state):
  - Register mode_down.
  - Count = 0 in up mode, or load_bcd in down mode. Any load digit > 9 is clamped to 9.
  - Prescaler cleared; expired, overflow and lap_active cleared.
  - Next state RUNNING. In down mode with a load value of 0, next state is EXPIRED with expired=1 instead.
- Prescaler:
  - Increments only in RUNNING.
  - At TICKS_PER_UNIT-1 it wraps to 0 and issues a tick.
  - Held, not cleared, in PAUSED, so the fractional unit is preserved.
- Tick effect: the count changes on the clock edge following the prescaler terminal cycle. Each digit counts 0..9 with carry (up) or borrow (down).
- Up wrap: all-9s + 1 → all-0s, overflow=1, keeps running.
- Down zero: the tick producing all-0s sets expired=1 in the same update. State becomes EXPIRED; the count holds at 0.
- Lap:
  - First pulse in RUNNING or PAUSED copies the live count into the snapshot and sets lap_active=1.
  - Second pulse clears lap_active.
  - Ignored in IDLE and EXPIRED.
  - Entering EXPIRED releases the freeze.
- Output latency: digits_bcd reflects the count/snapshot register value. No extra pipeline stage beyond the registers.

Optional Feature:
- Macro: BCD_LAP_STOPWATCH_LAP_EN.
- Defined: lap behaviour exactly as above.
- Undefined: no snapshot register; lap input ignored; lap_active tied 0; digits_bcd always shows the live count.

Decomposition:
- Package stopwatch_pkg:
  - State enum {IDLE, RUNNING, PAUSED, EXPIRED}.
  - BCD_DIGIT_W = 4, BCD_MAX = 4'd9.
  - Function for clamping a BCD digit.
- Sub-module bcd_digit_counter:
  - One digit, registered.
  - Inputs: en, down, load, load_val, carry_in.
  - Output: carry_out (9→0 up, or 0→9 down).
  - Instantiated NUM_DIGITS times with a generate loop; carry chained.

Test Plan (NUM_DIGITS=2, TICKS_PER_UNIT=4):
- Up count: start with mode_down=0, run 40 clk → digits_bcd=8'h10, running=1, overflow=0.
- Pause holds: pause at count 8'h03 after 2 prescaler cycles, wait 20 clk, resume → next increment to 8'h04 occurs exactly 2 clk after resume.
- Up wrap: run from 0 for 100 units → digits_bcd=8'h00, overflow=1, still running.
- Countdown: start with mode_down=1, load_bcd=8'h03 → 8'h02, 8'h01, 8'h00 at 4-clk spacing; expired=1 and state EXPIRED at 8'h00; continue_pause then ignored.
- Lap: lap at count 8'h05, run to 8'h09 → digits_bcd stays 8'h05, lap_active=1; second lap → 8'h09. Without the macro, digits_bcd=8'h09 throughout.
- Priority and reset: start and continue_pause in the same cycle → RUNNING from 0. load_bcd=8'hF2 → clamped to 8'h92. sync_reset mid-run → all outputs 0 on the next edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the BCD lap stopwatch: FSM state encoding,
// BCD digit constants and the load-value digit clamp.
package stopwatch_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } sw_state_e;

  // Non-decimal nibbles (A..F) saturate to 9
  function automatic logic [BCD_DIGIT_W-1:0] clamp_bcd_digit(
    input logic [BCD_DIGIT_W-1:0] d
  );
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One registered BCD digit (0..9) with load, count enable, direction and
// carry/borrow chaining to the next more significant digit.
module bcd_digit_counter
  import stopwatch_pkg::*;
(
  input  logic                   clk,
  input  logic                   sync_reset,
  input  logic                   en,
  input  logic                   down,
  input  logic                   load,
  input  logic [BCD_DIGIT_W-1:0] load_val,
  input  logic                   carry_in,
  output logic [BCD_DIGIT_W-1:0] digit,
  output logic                   carry_out
);

  logic at_limit_c;

  // Digit is about to roll over: 9->0 counting up, 0->9 counting down
  assign at_limit_c = down ? (digit == '0) : (digit == BCD_MAX);
  assign carry_out  = en && carry_in && at_limit_c;

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      digit <= '0;
    end else if (load) begin
      digit <= load_val;
    end else if (en && carry_in) begin
      if (at_limit_c) begin
        digit <= down ? BCD_MAX : '0;
      end else if (down) begin
        digit <= digit - BCD_DIGIT_W'(1);
      end else begin
        digit <= digit + BCD_DIGIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/bcd_lap_stopwatch.sv
// BCD up/down stopwatch with prescaler, pause, countdown expiry and optional
// lap freeze (enabled by defining BCD_LAP_STOPWATCH_LAP_EN).
module bcd_lap_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned TICKS_PER_UNIT = 50000000,
  parameter int unsigned PRESCALE_W     = 26
) (
  input  logic                              clk,
  input  logic                              sync_reset,
  input  logic                              start,
  input  logic                              continue_pause,
  input  logic                              lap,
  input  logic                              mode_down,
  input  logic [NUM_DIGITS*BCD_DIGIT_W-1:0] load_bcd,
  output logic [NUM_DIGITS*BCD_DIGIT_W-1:0] digits_bcd,
  output logic                              running,
  output logic                              lap_active,
  output logic                              expired,
  output logic                              overflow
);

  localparam int unsigned COUNT_W = NUM_DIGITS * BCD_DIGIT_W;
  localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(TICKS_PER_UNIT - 1);

  sw_state_e             state_q;
  sw_state_e             state_d;
  logic                  mode_q;
  logic [PRESCALE_W-1:0] presc_q;
  logic                  running_q;
  logic                  expired_q;
  logic                  overflow_q;

  logic [COUNT_W-1:0]    count_c;
  logic [COUNT_W-1:0]    load_val_c;
  logic [NUM_DIGITS:0]   carry_c;
  logic                  advance_c;
  logic                  tick_c;
  logic                  load_zero_c;
  logic                  hit_zero_c;
  logic                  wrap_c;

  // Up mode starts from zero; down mode loads the clamped preset
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_load
    assign load_val_c[g*BCD_DIGIT_W +: BCD_DIGIT_W] =
      mode_down ? clamp_bcd_digit(load_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W]) : '0;
  end

  assign load_zero_c = mode_down && (load_val_c == '0);
  assign tick_c      = advance_c && (presc_q == PRESC_LAST);
  // 0..01 in BCD is numerically 1, so the decrement that lands on zero is easy to spot
  assign hit_zero_c  = mode_q && tick_c && (count_c == COUNT_W'(1));
  assign wrap_c      = !mode_q && carry_c[NUM_DIGITS];

  // State register
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start overrides everything, then pause/resume
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = load_zero_c ? EXPIRED : RUNNING;
    end else begin
      case (state_q)
        RUNNING: begin
          if (continue_pause) begin
            state_d = PAUSED;
          end else if (hit_zero_c) begin
            state_d = EXPIRED;
          end
        end
        PAUSED: begin
          if (continue_pause) begin
            state_d = RUNNING;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Datapath control: time only advances while staying in RUNNING
  always_comb begin
    advance_c = 1'b0;
    if (!start && (state_q == RUNNING) && !continue_pause) begin
      advance_c = 1'b1;
    end
  end

  assign carry_c[0] = tick_c;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit_counter u_digit (
      .clk        (clk),
      .sync_reset (sync_reset),
      .en         (advance_c),
      .down       (mode_q),
      .load       (start),
      .load_val   (load_val_c[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .carry_in   (carry_c[g]),
      .digit      (count_c[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .carry_out  (carry_c[g+1])
    );
  end

  // Prescaler, mode and sticky status flags
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      mode_q     <= 1'b0;
      presc_q    <= '0;
      running_q  <= 1'b0;
      expired_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      running_q <= (state_d == RUNNING);
      if (start) begin
        mode_q     <= mode_down;
        presc_q    <= '0;
        expired_q  <= load_zero_c;
        overflow_q <= 1'b0;
      end else begin
        if (advance_c) begin
          presc_q <= tick_c ? '0 : presc_q + PRESCALE_W'(1);
        end
        if (hit_zero_c) begin
          expired_q <= 1'b1;
        end
        if (wrap_c) begin
          overflow_q <= 1'b1;
        end
      end
    end
  end

  assign running  = running_q;
  assign expired  = expired_q;
  assign overflow = overflow_q;

`ifdef BCD_LAP_STOPWATCH_LAP_EN
  logic [COUNT_W-1:0] snap_q;
  logic               lap_q;
  logic               do_lap_c;

  assign do_lap_c = lap && !start && !continue_pause &&
                    ((state_q == RUNNING) || (state_q == PAUSED));

  // Lap toggles the freeze; restart or expiry releases it
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      lap_q  <= 1'b0;
      snap_q <= '0;
    end else if (start || hit_zero_c) begin
      lap_q <= 1'b0;
    end else if (do_lap_c) begin
      lap_q <= !lap_q;
      if (!lap_q) begin
        snap_q <= count_c;
      end
    end
  end

  assign lap_active = lap_q;
  assign digits_bcd = lap_q ? snap_q : count_c;
`else
  logic lap_unused;

  assign lap_unused = lap;
  assign lap_active = 1'b0;
  assign digits_bcd = count_c;
`endif

endmodule

// File: tb/tb_bcd_lap_stopwatch.sv
// Bench for bcd_lap_stopwatch (2 digits, 4 clk per unit): directed vector
// table, hand-written pause/lap/wrap sequences and random pulses vs a model.
module tb_bcd_lap_stopwatch;

  localparam int unsigned ND   = 2;
  localparam int unsigned TPU  = 4;
  localparam int unsigned PW   = 3;
  localparam int unsigned CW   = ND * 4;
  localparam int          MAXV = (10 ** ND) - 1;
`ifdef BCD_LAP_STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  localparam int PH_IDLE = 0, PH_RUN = 1, PH_PAUSE = 2, PH_EXP = 3;

  logic          clk = 1'b0;
  logic          sync_reset = 1'b0;
  logic          start = 1'b0;
  logic          continue_pause = 1'b0;
  logic          lap = 1'b0;
  logic          mode_down = 1'b0;
  logic [CW-1:0] load_bcd = '0;
  logic [CW-1:0] digits_bcd;
  logic          running;
  logic          lap_active;
  logic          expired;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: plain integers for count and snapshot
  int m_phase = PH_IDLE;
  int m_count = 0;
  int m_snap  = 0;
  int m_presc = 0;
  bit m_down  = 1'b0;
  bit m_ovf   = 1'b0;
  bit m_exp   = 1'b0;
  bit m_lap   = 1'b0;

  bcd_lap_stopwatch #(
    .NUM_DIGITS     (ND),
    .TICKS_PER_UNIT (TPU),
    .PRESCALE_W     (PW)
  ) dut (
    .clk            (clk),
    .sync_reset     (sync_reset),
    .start          (start),
    .continue_pause (continue_pause),
    .lap            (lap),
    .mode_down      (mode_down),
    .load_bcd       (load_bcd),
    .digits_bcd     (digits_bcd),
    .running        (running),
    .lap_active     (lap_active),
    .expired        (expired),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] to_bcd(input int v);
    logic [CW-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < ND; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int load_value(input logic [CW-1:0] ld);
    int v;
    int w;
    int d;
    v = 0;
    w = 1;
    for (int i = 0; i < ND; i++) begin
      d = int'(ld[i*4 +: 4]);
      if (d > 9) d = 9;
      v = v + d * w;
      w = w * 10;
    end
    return v;
  endfunction

  task automatic unit_elapsed();
    if (!m_down) begin
      if (m_count == MAXV) begin
        m_count = 0;
        m_ovf   = 1'b1;
      end else begin
        m_count = m_count + 1;
      end
    end else begin
      m_count = m_count - 1;
      if (m_count == 0) begin
        m_exp   = 1'b1;
        m_phase = PH_EXP;
        m_lap   = 1'b0;
      end
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit cp, input bit lp,
                            input bit md, input logic [CW-1:0] ld);
    bit adv;
    if (r) begin
      m_phase = PH_IDLE; m_count = 0; m_snap = 0; m_presc = 0;
      m_down = 1'b0; m_ovf = 1'b0; m_exp = 1'b0; m_lap = 1'b0;
      return;
    end
    adv = !s && (m_phase == PH_RUN) && !cp;
    if (s) begin
      m_down = md; m_presc = 0; m_ovf = 1'b0; m_exp = 1'b0; m_lap = 1'b0;
      m_count = md ? load_value(ld) : 0;
      if (md && m_count == 0) begin
        m_phase = PH_EXP;
        m_exp   = 1'b1;
      end else begin
        m_phase = PH_RUN;
      end
    end else if (cp && m_phase == PH_RUN) begin
      m_phase = PH_PAUSE;
    end else if (cp && m_phase == PH_PAUSE) begin
      m_phase = PH_RUN;
    end else if (lp && LAP_EN && (m_phase == PH_RUN || m_phase == PH_PAUSE)) begin
      if (!m_lap) m_snap = m_count;
      m_lap = !m_lap;
    end
    if (adv) begin
      if (m_presc == TPU - 1) begin
        m_presc = 0;
        unit_elapsed();
      end else begin
        m_presc = m_presc + 1;
      end
    end
  endtask

  task automatic cycle(input bit r, input bit s, input bit cp, input bit lp,
                       input bit md, input logic [CW-1:0] ld);
    sync_reset = r; start = s; continue_pause = cp; lap = lp;
    mode_down = md; load_bcd = ld;
    model_step(r, s, cp, lp, md, ld);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic check(input string nm, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit            rst, st, cp, lp, md;
    logic [CW-1:0] ld;
    int            hold;
    logic [CW-1:0] digits;
    bit            run, exp, ovf;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  initial begin
    //           rst st cp lp md  load   hold digits run exp ovf
    vecs[0]  = '{1, 0, 0, 0, 0, 8'h00,  0, 8'h00, 0, 0, 0};
    vecs[1]  = '{0, 1, 0, 0, 0, 8'h00,  0, 8'h00, 1, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 0, 8'h00, 39, 8'h10, 1, 0, 0};
    vecs[3]  = '{0, 0, 1, 0, 0, 8'h00, 20, 8'h10, 0, 0, 0};
    vecs[4]  = '{0, 0, 1, 0, 0, 8'h00,  0, 8'h10, 1, 0, 0};
    vecs[5]  = '{0, 0, 0, 0, 0, 8'h00,  2, 8'h10, 1, 0, 0};
    vecs[6]  = '{0, 0, 0, 0, 0, 8'h00,  0, 8'h11, 1, 0, 0};
    vecs[7]  = '{0, 1, 0, 0, 1, 8'h03,  0, 8'h03, 1, 0, 0};
    vecs[8]  = '{0, 0, 0, 0, 0, 8'h00,  2, 8'h03, 1, 0, 0};
    vecs[9]  = '{0, 0, 0, 0, 0, 8'h00,  0, 8'h02, 1, 0, 0};
    vecs[10] = '{0, 0, 0, 0, 0, 8'h00,  3, 8'h01, 1, 0, 0};
    vecs[11] = '{0, 0, 0, 0, 0, 8'h00,  3, 8'h00, 0, 1, 0};
    vecs[12] = '{0, 0, 1, 0, 0, 8'h00,  5, 8'h00, 0, 1, 0};
    vecs[13] = '{0, 1, 1, 0, 1, 8'hF2,  0, 8'h92, 1, 0, 0};
    vecs[14] = '{0, 1, 0, 0, 1, 8'h00,  0, 8'h00, 0, 1, 0};
    vecs[15] = '{0, 1, 1, 0, 0, 8'h00,  0, 8'h00, 1, 0, 0};
    vecs[16] = '{0, 0, 0, 0, 0, 8'h00,  5, 8'h01, 1, 0, 0};
    vecs[17] = '{1, 0, 0, 0, 0, 8'h00,  0, 8'h00, 0, 0, 0};
    vecs[18] = '{0, 1, 0, 0, 1, 8'h9A,  0, 8'h99, 1, 0, 0};
    vecs[19] = '{1, 1, 0, 0, 1, 8'h45,  0, 8'h00, 0, 0, 0};

    for (int i = 0; i < NV; i++) begin
      cycle(vecs[i].rst, vecs[i].st, vecs[i].cp, vecs[i].lp, vecs[i].md, vecs[i].ld);
      idle(vecs[i].hold);
      check($sformatf("vec%0d_digits", i), digits_bcd, vecs[i].digits);
      check($sformatf("vec%0d_running", i), running, vecs[i].run);
      check($sformatf("vec%0d_expired", i), expired, vecs[i].exp);
      check($sformatf("vec%0d_overflow", i), overflow, vecs[i].ovf);
      check($sformatf("vec%0d_lap_active", i), lap_active, 0);
    end

    // Pause two prescaler cycles into unit 3; increment lands 2 clk after resume
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    idle(12);
    check("pause_pre", digits_bcd, 8'h03);
    idle(2);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle(20);
    check("pause_hold", digits_bcd, 8'h03);
    check("pause_running", running, 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle(1);
    check("resume_plus1", digits_bcd, 8'h03);
    idle(1);
    check("resume_plus2", digits_bcd, 8'h04);

    // Lap freeze at 05 while live count runs on to 09
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    idle(20);
    check("lap_pre", digits_bcd, 8'h05);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    idle(15);
    check("lap_frozen", digits_bcd, LAP_EN ? 8'h05 : 8'h09);
    check("lap_active_on", lap_active, LAP_EN);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    check("lap_release", digits_bcd, 8'h09);
    check("lap_active_off", lap_active, 0);

    // 100 units from zero wraps to 00 with sticky overflow
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    idle(396);
    check("wrap_pre_digits", digits_bcd, 8'h99);
    check("wrap_pre_ovf", overflow, 0);
    idle(4);
    check("wrap_digits", digits_bcd, 8'h00);
    check("wrap_ovf", overflow, 1);
    check("wrap_running", running, 1);
    idle(8);
    check("wrap_ovf_sticky", overflow, 1);

    // Random pulse traffic checked every cycle against the model
    for (int c = 0; c < 3000; c++) begin
      cycle(($urandom_range(0, 499) == 0),
            ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 1)),
            CW'($urandom));
      check("rand_digits", digits_bcd, to_bcd(m_lap ? m_snap : m_count));
      check("rand_running", running, (m_phase == PH_RUN));
      check("rand_lap_active", lap_active, m_lap);
      check("rand_expired", expired, m_exp);
      check("rand_overflow", overflow, m_ovf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
